vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: the maximum number of consecutive video grants while a CPU request is pending.
REQ-002 SHALL have ports:
- mclk  in  1  memory clock, the only clock
- rst_n  in  1  asynchronous, active-low reset
- vid_req  in  1  video read request
- vid_addr  in  18  video word address, held until vid_stb
- vid_data  out  16  video read data
- vid_stb  out  1  video data-valid strobe (mstb of the video controller)
- cpu_req  in  1  CPU request
- cpu_rnw  in  1  1 = read, 0 = write
- cpu_addr  in  18  CPU word address
- cpu_wdata  in  16  CPU write data
- cpu_be  in  2  byte enables, [1] = upper byte, [0] = lower byte
- cpu_rdata  out  16  CPU read data
- cpu_ack  out  1  CPU completion strobe
- sram_a  out  18  SRAM address
- sram_dq_o  out  16  SRAM write data
- sram_dq_oe  out  1  SRAM data bus output enable
- sram_dq_i  in  16  SRAM read data
- sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active low
REQ-003 SHALL use one clock, mclk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 SHALL drive every output from a register; no combinational path from any input to any output.
REQ-005 SHALL use a state machine with states IDLE, RD, RDONE, WR1, WR2, WDONE.
REQ-006 IDLE: SHALL sample the requests each cycle. On a grant: sram_a <= granted address; next state is RD for a read, WR1 for a CPU write.
REQ-007 Arbitration: video SHALL win over CPU, unless cpu_req=1 and starve_cnt==STARVE_MAX, in which case CPU SHALL win.
REQ-008 starve_cnt SHALL increment on each video grant made while cpu_req=1, saturating at STARVE_MAX. It SHALL clear to 0 on any CPU grant.
REQ-009 RD: SHALL drive sram_oe_n=0, sram_ub_n=0, sram_lb_n=0. At the end of the cycle it SHALL capture sram_dq_i into the read-data register of the granted client.
REQ-010 RDONE: SHALL assert for exactly one cycle either vid_stb=1 with vid_data valid, or cpu_ack=1 with cpu_rdata valid; next state is IDLE.
REQ-011 Video read latency: vid_req high in IDLE cycle N SHALL produce vid_stb high in cycle N+2. vid_data SHALL be stable throughout that stb cycle.
REQ-012 WR1: SHALL drive sram_dq_o=cpu_wdata (registered at grant) with sram_dq_oe=1, and sram_ub_n=~cpu_be[1], sram_lb_n=~cpu_be[0].
REQ-013 WR2: SHALL drive sram_we_n=0 and hold the address, data and byte lanes.
REQ-014 WDONE: SHALL drive sram_we_n=1 while keeping sram_dq_oe=1, so data holds past the WE rising edge. It SHALL assert cpu_ack=1; next state is IDLE.
REQ-015 sram_dq_oe SHALL never be 1 in the same cycle as sram_oe_n=0.
REQ-016 Every access SHALL take exactly 3 cycles. There SHALL be no back-to-back grant from the DONE states.
REQ-017 Once granted, an access SHALL complete and strobe even if the request is withdrawn mid-access. The client ignores the strobe.
REQ-018 A write with cpu_be=00 SHALL run the full write cycle with both byte strobes high (no SRAM change) and SHALL be acknowledged.
REQ-019 Reads SHALL always enable both bytes, regardless of cpu_be.
REQ-020 vid_stb and cpu_ack SHALL never both be 1 in the same cycle.
REQ-021 Address arithmetic: none. Addresses pass through unmodified; bits 17:0 cover 256K words.

Reset
REQ-022 While rst_n=0, outputs SHALL be:
- sram_we_n=1, sram_oe_n=1, sram_ub_n=1, sram_lb_n=1
- sram_dq_oe=0, sram_a=0, sram_dq_o=0
- vid_stb=0, vid_data=0, cpu_ack=0, cpu_rdata=0
- state=IDLE, starve_cnt=0
REQ-023 Reset asserted mid-write SHALL force sram_we_n=1 and sram_dq_oe=0 immediately (asynchronously). No ack SHALL follow after release.
REQ-024 After rst_n deasserts, the first grant SHALL occur no earlier than the first mclk edge at which rst_n is sampled high.

Verification
REQ-025 Video read: SRAM[0x0B000]=0x1234; vid_req=1, vid_addr=0x0B000 in IDLE at cycle N -> vid_stb=1 and vid_data=0x1234 at N+2; sram_oe_n=0 at N+1 only.
REQ-026 Byte write: cpu write of addr 0x00100, wdata 0xABCD, be=01 -> sram_we_n low for one cycle, sram_lb_n=0, sram_ub_n=1; cpu_ack 3 cycles after grant; read-back of a word that held 0x5555 returns 0x55CD.
REQ-027 Starvation: vid_req held at 1 and cpu_req=1 read -> exactly 4 video strobes, then cpu_ack; then video resumes and starve_cnt=0.
REQ-028 Simultaneous requests with starve_cnt=0 -> video granted first; CPU acked 3 cycles later.
REQ-029 Reset mid-access: rst_n low during WR2 -> sram_we_n=1 and sram_dq_oe=0 without an mclk edge; no cpu_ack after release; SRAM contents are not checked.
REQ-030 Withdrawn request: vid_req dropped in RD -> vid_stb still asserted in RDONE, then IDLE with no further access.

Source files
------------

// File: rtl/vram_arbiter.sv
// Two-client (video/CPU) arbiter for a single-port async SRAM.
// Video has priority; a CPU request is forced through after STARVE_MAX consecutive video grants.
module vram_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        vid_req,
  input  logic [17:0] vid_addr,
  output logic [15:0] vid_data,
  output logic        vid_stb,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [17:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic [1:0]  cpu_be,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic [17:0] sram_a,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [2:0] {IDLE, RD, RDONE, WR1, WR2, WDONE} state_t;

  state_t        state_q;
  logic [CW-1:0] starve_q;
  logic          cpu_sel_q;
  logic          cpu_win_d;
  logic          vid_win_d;

  // The CPU only beats a pending video request once it has been starved long enough.
  always_comb begin
    cpu_win_d = cpu_req && (!vid_req || (starve_q == STARVE_LIM));
    vid_win_d = vid_req && !cpu_win_d;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      cpu_sel_q  <= 1'b0;
      sram_a     <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      vid_stb    <= 1'b0;
      vid_data   <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      vid_stb <= 1'b0;
      cpu_ack <= 1'b0;
      case (state_q)
        IDLE: begin
          // Strobes are registered here so they are already valid in the first access cycle.
          if (vid_win_d) begin
            sram_a    <= vid_addr;
            cpu_sel_q <= 1'b0;
            sram_oe_n <= 1'b0;
            sram_ub_n <= 1'b0;
            sram_lb_n <= 1'b0;
            state_q   <= RD;
            if (cpu_req && (starve_q != STARVE_LIM)) starve_q <= starve_q + CW'(1);
          end else if (cpu_win_d) begin
            sram_a    <= cpu_addr;
            cpu_sel_q <= 1'b1;
            starve_q  <= '0;
            if (cpu_rnw) begin
              sram_oe_n <= 1'b0;
              sram_ub_n <= 1'b0;
              sram_lb_n <= 1'b0;
              state_q   <= RD;
            end else begin
              sram_dq_o  <= cpu_wdata;
              sram_dq_oe <= 1'b1;
              sram_ub_n  <= ~cpu_be[1];
              sram_lb_n  <= ~cpu_be[0];
              state_q    <= WR1;
            end
          end
        end
        RD: begin
          sram_oe_n <= 1'b1;
          sram_ub_n <= 1'b1;
          sram_lb_n <= 1'b1;
          if (cpu_sel_q) begin
            cpu_rdata <= sram_dq_i;
            cpu_ack   <= 1'b1;
          end else begin
            vid_data <= sram_dq_i;
            vid_stb  <= 1'b1;
          end
          state_q <= RDONE;
        end
        RDONE: state_q <= IDLE;
        WR1: begin
          sram_we_n <= 1'b0;
          state_q   <= WR2;
        end
        WR2: begin
          // WE rises while data and lanes are still driven for hold time.
          sram_we_n <= 1'b1;
          cpu_ack   <= 1'b1;
          state_q   <= WDONE;
        end
        WDONE: begin
          sram_dq_oe <= 1'b0;
          sram_ub_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: stimulus pushes expected strobes into a queue,
// a negedge monitor pops and compares kind, cycle and data of every strobe.
module tb_vram_arbiter;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vid_req = 1'b0;
  logic [17:0] vid_addr = '0;
  logic [15:0] vid_data;
  logic        vid_stb;
  logic        cpu_req = 1'b0;
  logic        cpu_rnw = 1'b1;
  logic [17:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [1:0]  cpu_be = 2'b11;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic [17:0] sram_a;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_i;
  logic        sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;

  vram_arbiter dut (
    .mclk(mclk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_stb(vid_stb),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  // SRAM model: preloaded while reset is held, byte-lane writes while WE is low.
  logic [15:0] mem [0:262143];
  assign sram_dq_i = !sram_oe_n ? mem[sram_a] : 16'hDEAD;
  always @(posedge mclk) begin
    if (!rst_n) begin
      mem[18'h0B000] <= 16'h1234;
      mem[18'h00100] <= 16'h5555;
      mem[18'h00200] <= 16'hBEEF;
    end else if (!sram_we_n && sram_dq_oe) begin
      if (!sram_ub_n) mem[sram_a][15:8] <= sram_dq_o[15:8];
      if (!sram_lb_n) mem[sram_a][7:0]  <= sram_dq_o[7:0];
    end
  end

  typedef struct {
    bit          is_cpu;
    bit          chk;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   viol  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input bit is_cpu, input bit chk, input logic [15:0] d, input int c);
    exp_t e;
    e.is_cpu = is_cpu;
    e.chk    = chk;
    e.data   = d;
    e.cyc    = c;
    exp_q.push_back(e);
  endtask

  task automatic nxt();
    @(negedge mclk);
  endtask

  always @(negedge mclk) begin
    if (rst_n) begin
      if (!sram_oe_n && sram_dq_oe) viol++;
      if (vid_stb && cpu_ack) viol++;
      if (vid_stb || cpu_ack) begin
        $display("txn cycle=%0d %s data=0x%04h", cyc, cpu_ack ? "cpu_ack" : "vid_stb",
                 cpu_ack ? cpu_rdata : vid_data);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: vid_stb=%0b cpu_ack=%0b at cycle %0d, none required",
                   vid_stb, cpu_ack, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_is_cpu", 32'(cpu_ack), 32'(mon_e.is_cpu));
          check("strobe_cycle", cyc, mon_e.cyc);
          if (mon_e.chk) check("strobe_data", mon_e.is_cpu ? cpu_rdata : vid_data, mon_e.data);
        end
      end
    end
  end

  int n;

  initial begin
    // Reset state
    repeat (3) nxt();
    check("rst_strobes", {sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 4'b1111);
    check("rst_dq_oe", sram_dq_oe, 0);
    check("rst_sram_a", sram_a, 0);
    check("rst_dq_o", sram_dq_o, 0);
    check("rst_vid", {vid_stb, vid_data}, 0);
    check("rst_cpu", {cpu_ack, cpu_rdata}, 0);
    rst_n = 1'b1;
    nxt(); nxt();

    // Video read, request dropped during RD
    n = cyc; vid_req = 1'b1; vid_addr = 18'h0B000; push_exp(0, 1, 16'h1234, n + 2);
    nxt(); vid_req = 1'b0;
    check("vrd_oe_n", sram_oe_n, 0);
    check("vrd_addr", sram_a, 18'h0B000);
    check("vrd_lanes", {sram_ub_n, sram_lb_n}, 2'b00);
    nxt(); check("vrdone_oe_n", sram_oe_n, 1);
    nxt(); nxt(); check("vrd_no_reaccess", sram_oe_n, 1);

    // Byte write be=01 then full-word readback with be=00
    n = cyc; cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 18'h00100; cpu_wdata = 16'hABCD; cpu_be = 2'b01;
    push_exp(1, 0, 16'h0, n + 3);
    nxt(); cpu_req = 1'b0;
    check("wr1_dq_oe", sram_dq_oe, 1);
    check("wr1_dq_o", sram_dq_o, 16'hABCD);
    check("wr1_lanes", {sram_ub_n, sram_lb_n}, 2'b10);
    check("wr1_we_n", sram_we_n, 1);
    check("wr1_addr", sram_a, 18'h00100);
    nxt(); check("wr2_we_n", sram_we_n, 0); check("wr2_dq_oe", sram_dq_oe, 1);
    nxt(); check("wdone_we_n", sram_we_n, 1); check("wdone_dq_oe", sram_dq_oe, 1);
    nxt(); check("widle_dq_oe", sram_dq_oe, 0);
    n = cyc; cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_be = 2'b00; push_exp(1, 1, 16'h55CD, n + 2);
    nxt(); cpu_req = 1'b0;
    check("crd_lanes", {sram_ub_n, sram_lb_n}, 2'b00);
    check("crd_oe_n", sram_oe_n, 0);
    nxt(); nxt();

    // Write with no byte lanes: acknowledged, memory unchanged
    n = cyc; cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 18'h00200; cpu_wdata = 16'h1111; cpu_be = 2'b00;
    push_exp(1, 0, 16'h0, n + 3);
    nxt(); cpu_req = 1'b0; check("be0_lanes", {sram_ub_n, sram_lb_n}, 2'b11);
    nxt(); check("be0_we_n", sram_we_n, 0);
    nxt(); nxt();
    n = cyc; cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_be = 2'b11; push_exp(1, 1, 16'hBEEF, n + 2);
    nxt(); cpu_req = 1'b0;
    nxt(); nxt();

    // Starvation: 4 video grants, then the CPU read, then video resumes
    n = cyc; vid_req = 1'b1; vid_addr = 18'h0B000;
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 18'h00200;
    for (int k = 0; k < 4; k++) push_exp(0, 1, 16'h1234, n + 2 + 3 * k);
    push_exp(1, 1, 16'hBEEF, n + 14);
    push_exp(0, 1, 16'h1234, n + 17);
    repeat (13) nxt();
    cpu_req = 1'b0; check("starve_cpu_addr", sram_a, 18'h00200);
    repeat (3) nxt();
    vid_req = 1'b0;
    nxt(); nxt();

    // Simultaneous requests with a cleared counter: video first, CPU 3 cycles later
    n = cyc; vid_req = 1'b1; vid_addr = 18'h0B000;
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 18'h00100;
    push_exp(0, 1, 16'h1234, n + 2);
    push_exp(1, 1, 16'h55CD, n + 5);
    nxt(); vid_req = 1'b0;
    repeat (3) nxt();
    cpu_req = 1'b0;
    nxt(); nxt();

    // Reset during WR2: strobes released immediately, no ack afterwards
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 18'h00300; cpu_wdata = 16'h7777; cpu_be = 2'b11;
    nxt(); cpu_req = 1'b0;
    nxt(); check("rstwr_we_n_before", sram_we_n, 0);
    #2 rst_n = 1'b0;
    #1 check("rstwr_we_n_async", sram_we_n, 1);
    check("rstwr_dq_oe_async", sram_dq_oe, 0);
    nxt(); nxt();
    rst_n = 1'b1;
    repeat (6) nxt();
    check("rstwr_no_ack", cpu_ack, 0);

    // Normal video read after the reset
    n = cyc; vid_req = 1'b1; vid_addr = 18'h0B000; push_exp(0, 1, 16'h1234, n + 2);
    nxt(); vid_req = 1'b0;
    repeat (4) nxt();

    check("queue_drained", exp_q.size(), 0);
    check("protocol_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
